// File: rtl/bmd_256_replay_sched_if.sv
// ---------------------------------------------------------------------------
// bmd_256_replay_sched_if
// Bundles the two handshakes of the replay scheduler:
//   FIFO side : fifo_read_trigger, fifo_counter_empty, fifo_counter_value
//               (inputs to the scheduler), fifo_counter_read_en (pop strobe)
//   TX side   : tx_req / tx_late (scheduler out), tx_ack (TX engine in)
// Modports:
//   master - the scheduler (drives read_en, tx_req, tx_late)
//   slave  - the FIFO / TX engine environment
// ---------------------------------------------------------------------------
interface bmd_256_replay_sched_if #(
  parameter int CNT_W = 30
);
  logic             fifo_read_trigger;
  logic             fifo_counter_empty;
  logic [CNT_W-1:0] fifo_counter_value;
  logic             fifo_counter_read_en;
  logic             tx_req;
  logic             tx_ack;
  logic [CNT_W-1:0] tx_late;

  modport master (
    input  fifo_read_trigger,
    input  fifo_counter_empty,
    input  fifo_counter_value,
    output fifo_counter_read_en,
    output tx_req,
    input  tx_ack,
    output tx_late
  );

  modport slave (
    output fifo_read_trigger,
    output fifo_counter_empty,
    output fifo_counter_value,
    input  fifo_counter_read_en,
    input  tx_req,
    output tx_ack,
    input  tx_late
  );
endinterface

// File: rtl/bmd_256_replay_sched.sv
// ---------------------------------------------------------------------------
// bmd_256_replay_sched
// Pops RX arrival timestamps from the count/wait FIFO and paces TX requests
// so that each request goes out at the same offset from the first request
// as its timestamp has from the first timestamp.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   latency_reset_signal  synchronous abort/clear (wins over everything)
//   bus (master)          FIFO pop handshake and TX request/ack, tx_late
//   sched_busy            high whenever the FSM is not idle
//   sched_done            one-cycle pulse at the end of a burst
//   pkt_count             packets acknowledged in the current/last burst
//
// Optional feature (macro BMD_REPLAY_STATS_EN):
//   max_late  largest tx_late of the burst
//   late_cnt  number of requests issued with tx_late > 0
// ---------------------------------------------------------------------------
module bmd_256_replay_sched #(
  parameter int CNT_W = 30,
  parameter int NUM_W = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   latency_reset_signal,
  bmd_256_replay_sched_if.master bus,
  output logic                   sched_busy,
  output logic                   sched_done,
  output logic [NUM_W-1:0]       pkt_count
`ifdef BMD_REPLAY_STATS_EN
  ,
  output logic [CNT_W-1:0]       max_late,
  output logic [NUM_W-1:0]       late_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    LOAD = 3'd2,
    WAIT = 3'd3,
    REQ  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] target;
  logic             first;
  logic [CNT_W-1:0] late_now;

  // How far behind schedule the request is when the wait condition is met.
  assign late_now = timer - target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= IDLE;
      timer                    <= '0;
      base                     <= '0;
      target                   <= '0;
      first                    <= 1'b0;
      bus.fifo_counter_read_en <= 1'b0;
      bus.tx_req               <= 1'b0;
      bus.tx_late              <= '0;
      sched_busy               <= 1'b0;
      sched_done               <= 1'b0;
      pkt_count                <= '0;
`ifdef BMD_REPLAY_STATS_EN
      max_late                 <= '0;
      late_cnt                 <= '0;
`endif
    end else if (latency_reset_signal) begin
      state                    <= IDLE;
      timer                    <= '0;
      base                     <= '0;
      target                   <= '0;
      first                    <= 1'b0;
      bus.fifo_counter_read_en <= 1'b0;
      bus.tx_req               <= 1'b0;
      bus.tx_late              <= '0;
      sched_busy               <= 1'b0;
      sched_done               <= 1'b0;
      pkt_count                <= '0;
`ifdef BMD_REPLAY_STATS_EN
      max_late                 <= '0;
      late_cnt                 <= '0;
`endif
    end else begin
      bus.fifo_counter_read_en <= 1'b0;
      sched_done               <= 1'b0;

      // Replay timer: zero while idle, otherwise counts up and sticks at max.
      if (state == IDLE)
        timer <= '0;
      else if (!(&timer))
        timer <= timer + CNT_W'(1);

      case (state)
        IDLE: begin
          first <= 1'b1;
          if (bus.fifo_read_trigger && !bus.fifo_counter_empty) begin
            state                    <= POP;
            bus.fifo_counter_read_en <= 1'b1;
            sched_busy               <= 1'b1;
            pkt_count                <= '0;
`ifdef BMD_REPLAY_STATS_EN
            max_late                 <= '0;
            late_cnt                 <= '0;
`endif
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          // The first entry anchors the burst; later offsets are taken
          // modulo 2^CNT_W so a wrapped waiting_counter still works.
          if (first) begin
            base   <= bus.fifo_counter_value;
            target <= '0;
            timer  <= '0;
            first  <= 1'b0;
          end else begin
            target <= bus.fifo_counter_value - base;
          end
          state <= WAIT;
        end
        WAIT: begin
          if (timer >= target) begin
            state       <= REQ;
            bus.tx_req  <= 1'b1;
            bus.tx_late <= late_now;
`ifdef BMD_REPLAY_STATS_EN
            if (late_now != '0 && !(&late_cnt))
              late_cnt <= late_cnt + NUM_W'(1);
            if (late_now > max_late)
              max_late <= late_now;
`endif
          end
        end
        REQ: begin
          if (bus.tx_ack) begin
            bus.tx_req <= 1'b0;
            if (!(&pkt_count))
              pkt_count <= pkt_count + NUM_W'(1);
            if (bus.fifo_counter_empty) begin
              state      <= DONE;
              sched_done <= 1'b1;
            end else begin
              state                    <= POP;
              bus.fifo_counter_read_en <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
          bus.tx_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmd_256_replay_sched.sv
// ---------------------------------------------------------------------------
// tb_bmd_256_replay_sched
// Drives the scheduler with a queue-based FIFO model and a TX responder.
// Expected request times are derived from the timing rules: the first
// request comes 3 clocks after the first pop; request k comes at the later
// of (first request + offset of entry k) and (previous ack cycle + 4);
// tx_late is the request time relative to the first minus the offset.
// ---------------------------------------------------------------------------
module tb_bmd_256_replay_sched;
  localparam int CNT_W = 30;
  localparam int NUM_W = 13;
  localparam logic [CNT_W-1:0] MASK = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic             lrs;
  logic             sched_busy;
  logic             sched_done;
  logic [NUM_W-1:0] pkt_count;
`ifdef BMD_REPLAY_STATS_EN
  logic [CNT_W-1:0] max_late;
  logic [NUM_W-1:0] late_cnt;
`endif

  bmd_256_replay_sched_if #(.CNT_W(CNT_W)) bus ();

  bmd_256_replay_sched #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .latency_reset_signal (lrs),
    .bus                  (bus),
    .sched_busy           (sched_busy),
    .sched_done           (sched_done),
    .pkt_count            (pkt_count)
`ifdef BMD_REPLAY_STATS_EN
    ,
    .max_late             (max_late),
    .late_cnt             (late_cnt)
`endif
  );

  always #2 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [CNT_W-1:0] fifo_q[$];
  logic [CNT_W-1:0] vals[$];
  int               dly[$];
  logic             re_prev;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock; FIFO dout updates one clock after a pop strobe.
  task automatic step();
    re_prev = bus.fifo_counter_read_en;
    @(posedge clk);
    #1;
    cyc++;
    if (re_prev && fifo_q.size() > 0) bus.fifo_counter_value = fifo_q.pop_front();
    bus.fifo_counter_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_burst(input string name, input bit stray);
    int n, k, first_re, last_ack, ack_at, rdcnt, donecnt, late_n;
    longint r0, exp_r, exp_late, max_l, tgt;
    logic [CNT_W-1:0] d;
    bit prev_req, fin;
    n = vals.size(); k = 0; first_re = -1; last_ack = 0; ack_at = -1;
    rdcnt = 0; donecnt = 0; late_n = 0; r0 = 0; max_l = 0;
    prev_req = 1'b0; fin = 1'b0;
    fifo_q = vals;
    bus.fifo_counter_empty = (fifo_q.size() == 0);
    bus.fifo_read_trigger  = 1'b1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      step();
      bus.tx_ack = 1'b0;
      if (bus.fifo_counter_read_en) begin
        rdcnt++;
        if (first_re < 0) begin
          first_re = cyc;
          bus.fifo_read_trigger = 1'b0;   // dropping mid-burst must not matter
        end
      end
      if (bus.tx_req && !prev_req && k < n) begin
        d   = vals[k] - vals[0];
        tgt = longint'(d);
        if (k == 0) begin
          r0    = first_re + 3;
          exp_r = r0;
        end else begin
          exp_r = (r0 + tgt > last_ack + 4) ? r0 + tgt : last_ack + 4;
        end
        exp_late = exp_r - r0 - tgt;
        check($sformatf("%s req%0d_cycle", name, k), cyc, exp_r);
        check($sformatf("%s req%0d_late", name, k), bus.tx_late, exp_late);
        check($sformatf("%s req%0d_pkt_count", name, k), pkt_count, k);
        if (exp_late > 0) late_n++;
        if (exp_late > max_l) max_l = exp_late;
        ack_at = cyc + dly[k];
        k++;
      end else if (stray && sched_busy && !bus.tx_req && $urandom_range(7) == 0) begin
        bus.tx_ack = 1'b1;
      end
      if (cyc == ack_at) begin
        bus.tx_ack = 1'b1;
        last_ack   = cyc;
      end
      prev_req = bus.tx_req;
      if (sched_done) begin
        donecnt++;
        fin = 1'b1;
      end
    end
    bus.tx_ack = 1'b0;
    check({name, " done_seen"}, fin, 1);
    step();
    check({name, " busy_after"}, sched_busy, 0);
    check({name, " done_pulse"}, sched_done, 0);
    check({name, " pkt_count"}, pkt_count, n);
    check({name, " read_en_pulses"}, rdcnt, n);
    check({name, " done_count"}, donecnt, 1);
`ifdef BMD_REPLAY_STATS_EN
    check({name, " late_cnt"}, late_cnt, late_n);
    check({name, " max_late"}, max_late, max_l);
`endif
  endtask

  initial begin
    int n, rd, seen;
    logic [CNT_W-1:0] v;
    rst = 1'b1; lrs = 1'b0;
    bus.fifo_read_trigger = 1'b0; bus.fifo_counter_empty = 1'b1;
    bus.fifo_counter_value = '0; bus.tx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", sched_busy, 0);
    check("rst tx_req", bus.tx_req, 0);
    check("rst read_en", bus.fifo_counter_read_en, 0);
    check("rst tx_late", bus.tx_late, 0);
    check("rst pkt_count", pkt_count, 0);
    check("rst done", sched_done, 0);
    rst = 1'b0;
    step();

    // Trigger with an empty FIFO: stay idle.
    bus.fifo_read_trigger = 1'b1;
    rd = 0; seen = 0;
    repeat (10) begin
      step();
      if (bus.fifo_counter_read_en) rd++;
      if (sched_busy) seen++;
    end
    check("empty_idle read_en", rd, 0);
    check("empty_idle busy", seen, 0);
    bus.fifo_read_trigger = 1'b0;
    step();

    vals = {30'd100, 30'd110, 30'd130}; dly = {1, 1, 1};
    run_burst("spaced", 1'b0);
    vals = {30'd100, 30'd101, 30'd102}; dly = {1, 1, 1};
    run_burst("tight", 1'b0);
    vals = {MASK - 30'd4, 30'd3}; dly = {1, 1};
    run_burst("wrap", 1'b0);
    vals = {30'd100, 30'd110, 30'd130}; dly = {1, 50, 1};
    run_burst("slow_ack", 1'b1);

    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 6);
      vals.delete(); dly.delete();
      if ($urandom_range(1) == 1) v = CNT_W'($urandom);
      else v = MASK - CNT_W'($urandom_range(20));
      for (int i = 0; i < n; i++) begin
        vals.push_back(v);
        v = v + CNT_W'($urandom_range(25));
        dly.push_back(($urandom_range(7) == 0) ? 40 : int'($urandom_range(1, 5)));
      end
      run_burst($sformatf("rnd%0d", b), 1'b1);
    end

    // Synchronous abort during the wait for entry 2 of 4.
    fifo_q = {30'd0, 30'd40, 30'd80, 30'd120};
    bus.fifo_counter_empty = 1'b0;
    bus.fifo_read_trigger  = 1'b1;
    rd = 0;
    for (int c = 0; c < 200 && rd < 2; c++) begin
      step();
      bus.tx_ack = bus.tx_req && !bus.tx_ack;
      if (bus.fifo_counter_read_en) rd++;
    end
    check("abort second_pop", rd, 2);
    bus.tx_ack = 1'b0;
    step();
    step();
    lrs = 1'b1;
    bus.fifo_read_trigger = 1'b0;
    step();
    lrs = 1'b0;
    check("abort busy", sched_busy, 0);
    check("abort tx_req", bus.tx_req, 0);
    check("abort pkt_count", pkt_count, 0);
`ifdef BMD_REPLAY_STATS_EN
    check("abort late_cnt", late_cnt, 0);
    check("abort max_late", max_late, 0);
`endif
    rd = 0;
    repeat (20) begin
      step();
      if (bus.fifo_counter_read_en) rd++;
    end
    check("abort no_pop", rd, 0);
    fifo_q.delete();
    bus.fifo_counter_empty = 1'b1;
    step();

    // Asynchronous reset while a request is pending.
    fifo_q = {30'd5, 30'd6};
    bus.fifo_counter_empty = 1'b0;
    bus.fifo_read_trigger  = 1'b1;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      step();
      if (bus.tx_req) seen = 1;
    end
    check("async req_reached", seen, 1);
    rst = 1'b1;
    #1;
    check("async tx_req", bus.tx_req, 0);
    check("async busy", sched_busy, 0);
    check("async read_en", bus.fifo_counter_read_en, 0);
    check("async pkt_count", pkt_count, 0);
    bus.fifo_read_trigger = 1'b0;
    fifo_q.delete();
    bus.fifo_counter_empty = 1'b1;
    rst = 1'b0;
    step();
    step();
    check("post_rst busy", sched_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
